// File: rtl/stack_ctrl.sv
// Push/pop sequencer between the control unit and the stack memory port.
// Optional over/underflow guard is enabled by defining STACK_GUARD_EN.
module stack_ctrl #(
  parameter logic [15:0] STACK_TOP   = 16'h01FF,
  parameter logic [15:0] STACK_LIMIT = 16'h0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  input  logic [15:0] sp_in,
  output logic        sp_dec,
  output logic        sp_inc,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [15:0] mem_rdata,
  input  logic        clr_err,
  output logic        ovf,
  output logic        udf
);

  typedef enum logic [2:0] {
    IDLE, PUSH_WR, PUSH_DEC, POP_INC, POP_RD, POP_CAP, DONE
  } state_t;

  state_t      state;
  logic [15:0] addr_q;
  logic        blocked;

`ifdef STACK_GUARD_EN
  logic ovf_set, udf_set;

  // Guard looks at the pointer as it stands on the accept edge.
  assign ovf_set = req_valid && req_ready && !req_op && (sp_in < STACK_LIMIT);
  assign udf_set = req_valid && req_ready &&  req_op && (sp_in >= STACK_TOP);
  assign blocked = ovf_set || udf_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (ovf_set)      ovf <= 1'b1;
      else if (clr_err) ovf <= 1'b0;
      if (udf_set)      udf <= 1'b1;
      else if (clr_err) udf <= 1'b0;
    end
  end
`else
  logic unused_cfg;

  assign blocked    = 1'b0;
  assign ovf        = 1'b0;
  assign udf        = 1'b0;
  assign unused_cfg = ^{clr_err, STACK_TOP, STACK_LIMIT};
`endif

  // The read address must follow sp_in combinationally: the pointer only
  // settles in the cycle after sp_inc, which is the POP_RD cycle itself.
  assign mem_addr = (state == PUSH_WR || state == POP_RD) ? sp_in : addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      sp_dec    <= 1'b0;
      sp_inc    <= 1'b0;
      addr_q    <= '0;
    end else begin
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      sp_dec    <= 1'b0;
      sp_inc    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            if (blocked) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (!req_op) begin
              state     <= PUSH_WR;
              mem_we    <= 1'b1;
              mem_wdata <= req_data;
            end else begin
              state  <= POP_INC;
              sp_inc <= 1'b1;
            end
          end
        end
        PUSH_WR: begin
          addr_q <= sp_in;
          sp_dec <= 1'b1;
          state  <= PUSH_DEC;
        end
        PUSH_DEC: begin
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
        POP_INC: begin
          mem_re <= 1'b1;
          state  <= POP_RD;
        end
        POP_RD: begin
          addr_q <= sp_in;
          state  <= POP_CAP;
        end
        POP_CAP: begin
          rsp_data  <= mem_rdata;
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: pointer/memory models plus a LIFO
// reference queue; guard scenarios depend on STACK_GUARD_EN.
module tb_stack_ctrl;

  localparam logic [15:0] TOP   = 16'h01FF;
  localparam logic [15:0] LIMIT = 16'h0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_op = 1'b0, clr_err = 1'b0;
  logic [15:0] req_data = '0;
  logic        req_ready, rsp_valid, rsp_err, sp_dec, sp_inc, mem_we, mem_re, ovf, udf;
  logic [15:0] rsp_data, sp_in, mem_addr, mem_wdata;
  logic [15:0] mem_rdata;

  always #5 clk = ~clk;

  stack_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .sp_in(sp_in), .sp_dec(sp_dec),
    .sp_inc(sp_inc), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .clr_err(clr_err), .ovf(ovf), .udf(udf)
  );

  // Environment: stack pointer and synchronous-read memory.
  logic [15:0] sp_q;
  logic        sp_ovr = 1'b0;
  logic [15:0] ovr_val = '0;
  logic [15:0] mem [0:65535];

  assign sp_in = sp_ovr ? ovr_val : sp_q;

  always @(posedge clk or negedge rst) begin
    if (!rst) sp_q <= TOP;
    else begin
      if (sp_dec) sp_q <= sp_q - 16'd1;
      if (sp_inc) sp_q <= sp_q + 16'd1;
    end
  end

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  int          errors = 0;
  int          checks = 0;
  logic [15:0] ref_stk[$];
  logic [15:0] rsp_hold = '0;
  bit          clr_with_req = 1'b0;

  function automatic logic [15:0] cur_sp();
    return TOP - 16'(ref_stk.size());
  endfunction

  task automatic apply_reset();
    rst = 1'b0; req_valid = 1'b0; clr_err = 1'b0; sp_ovr = 1'b0;
    ref_stk.delete();
    rsp_hold = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // One request, checked cycle by cycle against the expected strobe schedule.
  task automatic do_op(input logic op, input logic [15:0] d,
                       input logic [15:0] sp_exp, input logic blk);
    int          len;
    logic [15:0] exp_rd;
    logic [3:0]  exp_s, got_s;
    len    = blk ? 1 : (op ? 4 : 3);
    exp_rd = rsp_hold;
    if (!blk && op) exp_rd = ref_stk.pop_back();
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_idle: got %b exp 1", req_ready); end
    req_valid = 1'b1; req_op = op; req_data = d;
    clr_err = clr_with_req;
    @(negedge clk);
    req_valid = 1'b0; clr_err = 1'b0;
    for (int k = 1; k <= len; k++) begin
      exp_s = 4'b0000;
      if (!blk) begin
        if (!op && k == 1) exp_s = 4'b1000;
        if (!op && k == 2) exp_s = 4'b0010;
        if ( op && k == 1) exp_s = 4'b0001;
        if ( op && k == 2) exp_s = 4'b0100;
      end
      got_s = {mem_we, mem_re, sp_dec, sp_inc};
      checks++;
      if (got_s !== exp_s) begin errors++; $display("FAIL strobes op=%0b k=%0d: got %b exp %b", op, k, got_s, exp_s); end
      checks++;
      if (rsp_valid !== (k == len)) begin errors++; $display("FAIL rsp_valid op=%0b k=%0d: got %b", op, k, rsp_valid); end
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL ready_busy k=%0d: got %b exp 0", k, req_ready); end
      if (exp_s[3]) begin
        checks++;
        if (mem_addr !== sp_exp || mem_wdata !== d) begin
          errors++; $display("FAIL push_wr: got addr %h data %h exp %h %h", mem_addr, mem_wdata, sp_exp, d);
        end
      end
      if (exp_s[2]) begin
        checks++;
        if (mem_addr !== 16'(sp_exp + 16'd1)) begin
          errors++; $display("FAIL pop_addr: got %h exp %h", mem_addr, 16'(sp_exp + 16'd1));
        end
      end
      if (k == len) begin
        checks++;
        if (rsp_err !== blk || rsp_data !== exp_rd) begin
          errors++; $display("FAIL rsp: got err %b data %h exp %b %h", rsp_err, rsp_data, blk, exp_rd);
        end
      end
      if (k < len) @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL ready_return: got ready %b valid %b exp 1 0", req_ready, rsp_valid);
    end
    if (!blk && !op) ref_stk.push_back(d);
    if (!blk && op) rsp_hold = exp_rd;
    if (!sp_ovr) begin
      checks++;
      if (sp_in !== cur_sp()) begin errors++; $display("FAIL pointer: got %h exp %h", sp_in, cur_sp()); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, mem_we, mem_re, sp_dec, sp_inc, ovf, udf} !== 9'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b exp 0", {req_ready, rsp_valid, rsp_err, mem_we, mem_re, sp_dec, sp_inc, ovf, udf});
    end
    checks++;
    if (rsp_data !== 16'h0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      errors++; $display("FAIL reset_data: got %h %h %h exp 0", rsp_data, mem_addr, mem_wdata);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", req_ready); end
  endtask

  task automatic test_push_basic();
    do_op(1'b0, 16'hA5A5, cur_sp(), 1'b0);
    apply_reset();
  endtask

  task automatic test_push_pop();
    do_op(1'b0, 16'h1234, cur_sp(), 1'b0);
    do_op(1'b1, 16'h0000, cur_sp(), 1'b0);
  endtask

  task automatic test_lifo();
    do_op(1'b0, 16'h0001, cur_sp(), 1'b0);
    do_op(1'b0, 16'h0002, cur_sp(), 1'b0);
    do_op(1'b0, 16'h0003, cur_sp(), 1'b0);
    repeat (3) do_op(1'b1, 16'h0000, cur_sp(), 1'b0);
    checks++;
    if (sp_in !== TOP) begin errors++; $display("FAIL lifo_ptr: got %h exp %h", sp_in, TOP); end
  endtask

  task automatic test_random();
    logic op;
    for (int i = 0; i < 30; i++) begin
      if (ref_stk.size() == 0)      op = 1'b0;
      else if (ref_stk.size() >= 8) op = 1'b1;
      else                          op = 1'($urandom_range(0, 1));
      do_op(op, 16'($urandom), cur_sp(), 1'b0);
    end
    while (ref_stk.size() > 0) do_op(1'b1, 16'h0000, cur_sp(), 1'b0);
  endtask

`ifdef STACK_GUARD_EN
  task automatic test_guard();
    do_op(1'b1, 16'h0000, cur_sp(), 1'b1);
    checks++;
    if (udf !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL udf_set: got ovf %b udf %b exp 0 1", ovf, udf); end
    sp_ovr = 1'b1; ovr_val = 16'h00FF;
    do_op(1'b0, 16'hBEEF, 16'h00FF, 1'b1);
    checks++;
    if (ovf !== 1'b1 || udf !== 1'b1) begin errors++; $display("FAIL ovf_set: got ovf %b udf %b exp 1 1", ovf, udf); end
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    checks++;
    if (ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL clr_err: got ovf %b udf %b exp 0 0", ovf, udf); end
    clr_with_req = 1'b1;
    do_op(1'b0, 16'hBEEF, 16'h00FF, 1'b1);
    clr_with_req = 1'b0;
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL set_wins: got ovf %b exp 1", ovf); end
    ovr_val = LIMIT;
    do_op(1'b0, 16'h5A5A, LIMIT, 1'b0);
    apply_reset();
    checks++;
    if (ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL flags_reset: got ovf %b udf %b exp 0 0", ovf, udf); end
  endtask
`else
  task automatic test_guard();
    sp_ovr = 1'b1; ovr_val = 16'h00FF;
    do_op(1'b0, 16'hC3C3, 16'h00FF, 1'b0);
    checks++;
    if (ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL no_guard_flags: got ovf %b udf %b exp 0 0", ovf, udf); end
    apply_reset();
  endtask
`endif

  task automatic test_reset_mid();
    do_op(1'b0, 16'h7777, cur_sp(), 1'b0);
    @(negedge clk); req_valid = 1'b1; req_op = 1'b1; req_data = '0;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_re !== 1'b1) begin errors++; $display("FAIL pop_rd_reached: got %b exp 1", mem_re); end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({mem_we, mem_re, sp_dec, sp_inc, rsp_valid} !== 5'b0) begin
      errors++; $display("FAIL async_drop: got %b exp 0", {mem_we, mem_re, sp_dec, sp_inc, rsp_valid});
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL no_rsp_in_reset: got %b exp 0", rsp_valid); end
    end
    rst = 1'b1;
    ref_stk.delete();
    rsp_hold = '0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 16'h0) begin
      errors++; $display("FAIL post_reset: got ready %b valid %b data %h exp 1 0 0000", req_ready, rsp_valid, rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    logic        pend_op[$];
    logic [15:0] pend_exp[$];
    logic        flip, prev_done, cop;
    logic [15:0] cexp;
    int          accepts;
    flip = 1'b0; prev_done = 1'b0; accepts = 0;
    req_valid = 1'b1; req_op = 1'b0; req_data = 16'($urandom);
    for (int cyc = 0; cyc < 90; cyc++) begin
      if (flip) begin req_op = ~req_op; req_data = 16'($urandom); flip = 1'b0; end
      if (cyc == 80) req_valid = 1'b0;
      checks++;
      if ($countones({mem_we, mem_re, sp_dec, sp_inc}) > 1) begin
        errors++; $display("FAIL concurrent_strobes cyc=%0d: got %b", cyc, {mem_we, mem_re, sp_dec, sp_inc});
      end
      if (prev_done) begin
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready cyc=%0d: got %b exp 1", cyc, req_ready); end
      end
      prev_done = rsp_valid;
      if (rsp_valid) begin
        checks++;
        if (pend_op.size() == 0) begin
          errors++; $display("FAIL b2b_spurious_rsp cyc=%0d: got 1 exp 0", cyc);
        end else begin
          cop = pend_op.pop_front();
          cexp = pend_exp.pop_front();
          if (rsp_err !== 1'b0 || (cop && rsp_data !== cexp)) begin
            errors++; $display("FAIL b2b_rsp cyc=%0d: got err %b data %h exp 0 %h", cyc, rsp_err, rsp_data, cexp);
          end
        end
      end
      if (req_ready) begin
        checks++;
        if ({mem_we, mem_re, sp_dec, sp_inc, rsp_valid} !== 5'b0 || pend_op.size() != 0) begin
          errors++; $display("FAIL b2b_idle cyc=%0d: got %b pend %0d exp 0 0", cyc, {mem_we, mem_re, sp_dec, sp_inc, rsp_valid}, pend_op.size());
        end
        if (req_valid) begin
          accepts++;
          if (!req_op) begin ref_stk.push_back(req_data); cexp = req_data; end
          else cexp = ref_stk.pop_back();
          pend_op.push_back(req_op);
          pend_exp.push_back(cexp);
          flip = 1'b1;
        end
      end
      @(negedge clk);
    end
    checks++;
    if (accepts != 18 || pend_op.size() != 0) begin
      errors++; $display("FAIL b2b_count: got %0d accepts %0d pending exp 18 0", accepts, pend_op.size());
    end
  endtask

  initial begin
    test_reset();
    test_push_basic();
    test_push_pop();
    test_lifo();
    test_random();
    test_guard();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
